// File: rtl/jpeg_dequantizer.sv
// JPEG dequantizer: multiplies one 8x8 coefficient block by a loadable quantization
// table, LANES entries per clock, and hands the saturated result to the IDCT stage.

module jpeg_dequantizer_lane #(
    parameter int COEF_W = 8,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16
) (
    input  logic [COEF_W-1:0] coef,
    input  logic [Q_W-1:0]    q,
    output logic [OUT_W-1:0]  res
);
    localparam int PW = COEF_W + Q_W + 1;
    // Compare width covers both the product and the output range, so any OUT_W works.
    localparam int EW = ((PW > OUT_W) ? PW : OUT_W) + 1;

    logic signed [PW-1:0] a, b, p;
    logic signed [EW-1:0] pe, hi, lo;

    always_comb begin
        a   = {{(Q_W+1){coef[COEF_W-1]}}, coef};
        b   = {{(COEF_W+1){1'b0}}, q};
        p   = a * b;
        pe  = {{(EW-PW){p[PW-1]}}, p};
        hi  = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo  = ~hi;
        res = pe[OUT_W-1:0];
        if (pe > hi)      res = hi[OUT_W-1:0];
        else if (pe < lo) res = lo[OUT_W-1:0];
    end
endmodule

module jpeg_dequantizer #(
    parameter int COEF_W = 8,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16,
    parameter int LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*COEF_W-1:0]  in_block,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  qt_wr_en,
    input  logic [5:0]            qt_addr,
    input  logic [Q_W-1:0]        qt_data,
    output logic                  qt_busy,
    output logic [64*OUT_W-1:0]   out_block,
    output logic                  out_valid,
    input  logic                  out_ready
);
    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t state, state_nx;
    logic [5:0] idx;
    logic [63:0][COEF_W-1:0] coef_buf;
    logic [63:0][Q_W-1:0]    qt;
    logic [63:0][OUT_W-1:0]  res;

    // A table write landing on the accept edge must not affect that block,
    // so the overwritten entry is remembered and substituted during PROC.
    logic           ovr_vld;
    logic [5:0]     ovr_addr;
    logic [Q_W-1:0] ovr_data;

    logic [LANES-1:0][5:0]        lane_idx;
    logic [LANES-1:0][COEF_W-1:0] lane_coef;
    logic [LANES-1:0][Q_W-1:0]    lane_q;
    logic [LANES-1:0][OUT_W-1:0]  lane_res;

    logic accept, last;

    assign accept    = in_valid && in_ready;
    assign last      = ({1'b0, idx} + 7'(LANES)) == 7'd64;
    assign out_block = res;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        qt_busy   = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                qt_busy  = 1'b0;
                if (in_valid) state_nx = PROC;
            end
            PROC: if (last) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx[k]  = idx + 6'(k);
        assign lane_coef[k] = coef_buf[lane_idx[k]];
        assign lane_q[k]    = (ovr_vld && ovr_addr == lane_idx[k]) ? ovr_data : qt[lane_idx[k]];

        jpeg_dequantizer_lane #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) u_lane (
            .coef (lane_coef[k]),
            .q    (lane_q[k]),
            .res  (lane_res[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx      <= '0;
            coef_buf <= '0;
            res      <= '0;
            ovr_vld  <= 1'b0;
            ovr_addr <= '0;
            ovr_data <= '0;
            for (int i = 0; i < 64; i++) qt[i] <= Q_W'(1);
        end else begin
            if (state == IDLE && qt_wr_en) qt[qt_addr] <= qt_data;
            if (accept) begin
                coef_buf <= in_block;
                idx      <= '0;
                ovr_vld  <= qt_wr_en;
                ovr_addr <= qt_addr;
                ovr_data <= qt[qt_addr];
            end
            if (state == PROC) begin
                for (int k = 0; k < LANES; k++) res[lane_idx[k]] <= lane_res[k];
                idx <= idx + 6'(LANES);
            end
        end
    end
endmodule

// File: tb/tb_jpeg_dequantizer.sv
// Directed bench for jpeg_dequantizer: default instance plus an OUT_W=12 instance
// sharing the same inputs to exercise saturation.

module tb_jpeg_dequantizer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, qt_wr_en, out_ready;
    logic [511:0] in_block;
    logic [5:0]   qt_addr;
    logic [7:0]   qt_data;
    logic         in_ready, qt_busy, out_valid;
    logic [1023:0] out_block;
    logic         s_in_ready, s_qt_busy, s_out_valid;
    logic [767:0] s_out_block;

    int n_chk = 0;
    int n_fail = 0;
    int lat, ir_err, err;

    jpeg_dequantizer dut (
        .clk(clk), .rst(rst), .in_block(in_block), .in_valid(in_valid), .in_ready(in_ready),
        .qt_wr_en(qt_wr_en), .qt_addr(qt_addr), .qt_data(qt_data), .qt_busy(qt_busy),
        .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready)
    );

    jpeg_dequantizer #(.OUT_W(12)) dut_sat (
        .clk(clk), .rst(rst), .in_block(in_block), .in_valid(in_valid), .in_ready(s_in_ready),
        .qt_wr_en(qt_wr_en), .qt_addr(qt_addr), .qt_data(qt_data), .qt_busy(s_qt_busy),
        .out_block(s_out_block), .out_valid(s_out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint o16(input int i);
        return longint'($signed(out_block[i*16 +: 16]));
    endfunction

    function automatic longint o12(input int i);
        return longint'($signed(s_out_block[i*12 +: 12]));
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 64; i++) in_block[i*8 +: 8] = v;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        qt_wr_en = 1'b1;
        qt_addr  = 6'(a);
        qt_data  = d;
        tick;
        qt_wr_en = 1'b0;
    endtask

    // Bounded wait for out_valid; lat counts edges waited, ir_err counts in_ready highs.
    task automatic wait_out(output int l, output int ir);
        l  = 0;
        ir = 0;
        while (!out_valid && l < 40) begin
            tick;
            l++;
            ir += int'(in_ready);
        end
    endtask

    task automatic run(output int l, output int ir);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_out(l, ir);
        ir += 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; qt_wr_en = 1'b0; out_ready = 1'b1;
        qt_addr = '0; qt_data = '0; in_block = '0;
        tick; tick;
        rst = 1'b1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_qt_busy", longint'(qt_busy), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_zero", longint'(out_block == '0), 1);
        tick;

        // 1: identity table, latency
        for (int i = 0; i < 64; i++) in_block[i*8 +: 8] = 8'(i - 32);
        run(lat, ir_err);
        check("t1_latency", lat, 16);
        check("t1_in_ready_low", ir_err, 0);
        for (int i = 0; i < 64; i++) check("t1_out", o16(i), i - 32);
        tick;
        check("t1_in_ready_back", longint'(in_ready), 1);
        check("t1_out_valid_drop", longint'(out_valid), 0);

        // 2: table load and signs
        for (int i = 0; i < 64; i++) wr(i, 8'(i + 1));
        fill(8'd2);
        in_block[7:0]     = 8'h80;
        in_block[511:504] = 8'd127;
        run(lat, ir_err);
        check("t2_out0", o16(0), -128);
        check("t2_out63", o16(63), 8128);
        check("t2_out5", o16(5), 12);
        check("t2_out62", o16(62), 126);
        tick;

        // 3: write while busy, then write coincident with accept
        for (int i = 0; i < 64; i++) wr(i, 8'd2);
        fill(8'd3);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        qt_wr_en = 1'b1; qt_addr = 6'd0; qt_data = 8'd9;
        check("t3_busy", longint'(qt_busy), 1);
        tick;
        qt_wr_en = 1'b0;
        wait_out(lat, ir_err);
        check("t3_out0", o16(0), 6);
        check("t3_out1", o16(1), 6);
        tick;
        run(lat, ir_err);
        check("t3_dropped", o16(0), 6);
        tick;
        qt_wr_en = 1'b1; qt_addr = 6'd0; qt_data = 8'd9;
        in_valid = 1'b1;
        tick;
        qt_wr_en = 1'b0; in_valid = 1'b0;
        wait_out(lat, ir_err);
        check("t3_acc_wr_old", o16(0), 6);
        tick;
        run(lat, ir_err);
        check("t3_acc_wr_new", o16(0), 27);
        tick;

        // 4: backpressure
        out_ready = 1'b0;
        fill(8'd3);
        run(lat, ir_err);
        check("t4_valid", longint'(out_valid), 1);
        err = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                fill(8'd7);
                in_valid = 1'b1;
            end
            if (c == 7) in_valid = 1'b0;
            tick;
            err += int'(o16(0) != 27) + int'(o16(1) != 6) + int'(o16(63) != 6);
            err += int'(!out_valid) + int'(in_ready);
        end
        in_valid = 1'b0;
        check("t4_stable", err, 0);
        out_ready = 1'b1;
        check("t4_no_same_cycle_ready", longint'(in_ready), 0);
        tick;
        check("t4_hs_valid", longint'(out_valid), 0);
        check("t4_hs_ready", longint'(in_ready), 1);
        tick;
        check("t4_no_extra_block", longint'(qt_busy), 0);

        // 5: mid-block reset
        fill(8'd5);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("t5_valid", longint'(out_valid), 0);
        check("t5_ready", longint'(in_ready), 1);
        check("t5_busy", longint'(qt_busy), 0);
        check("t5_out_clear", o16(0), 0);
        run(lat, ir_err);
        check("t5_out0", o16(0), 5);
        check("t5_out1", o16(1), 5);
        check("t5_out63", o16(63), 5);
        tick;

        // 6: saturation on the OUT_W=12 instance
        wr(0, 8'd255); wr(1, 8'd255); wr(2, 8'd3); wr(3, 8'd128); wr(4, 8'd128);
        fill(8'd0);
        in_block[7:0]   = 8'h80;
        in_block[15:8]  = 8'd127;
        in_block[23:16] = 8'd10;
        in_block[31:24] = 8'd16;
        in_block[39:32] = 8'hF0;
        run(lat, ir_err);
        check("t6_sat_valid", longint'(s_out_valid), 1);
        check("t6_neg_clamp", o12(0), -2048);
        check("t6_pos_clamp", o12(1), 2047);
        check("t6_in_range", o12(2), 30);
        check("t6_pos_edge", o12(3), 2047);
        check("t6_neg_edge", o12(4), -2048);
        check("t6_wide_neg", o16(0), -32640);
        check("t6_wide_pos", o16(1), 32385);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
